// File: rtl/encoder_8to3.sv
// Registered priority encoder: compresses a request vector to the index of
// the winning set bit, with a valid flag (any bit set) and a multi-hot flag.
// All outputs come straight from flops, one clock after din/en are sampled.
module encoder_8to3 #(
    parameter int DIN_W        = 8,
    parameter int Y_W          = 3,
    parameter bit MSB_PRIORITY = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIN_W-1:0] din,
    input  logic             en,
    output logic [Y_W-1:0]   y,
    output logic             valid,
    output logic             multi
);

    logic           any;
    logic           cnt_gt1;
    logic [Y_W-1:0] idx;

    // Combinational encode: OR-reduce, detect a second set bit, pick the winner.
    always_comb begin
        // NOTE: every signal gets a default before the loop, so no path leaves
        // a value unassigned and no latch is inferred.
        any     = 1'b0;
        cnt_gt1 = 1'b0;
        idx     = '0;
        for (int i = 0; i < DIN_W; i++) begin
            // A bit set after an earlier one was already seen means two or more.
            if (din[i] && any) begin
                cnt_gt1 = 1'b1;
            end
            if (din[i]) begin
                any = 1'b1;
            end
        end
        // The last assignment in scan order wins, so scan toward the priority end.
        if (MSB_PRIORITY) begin
            for (int i = 0; i < DIN_W; i++) begin
                if (din[i]) begin
                    idx = Y_W'(i);
                end
            end
        end else begin
            for (int i = DIN_W - 1; i >= 0; i--) begin
                if (din[i]) begin
                    idx = Y_W'(i);
                end
            end
        end
    end

    // Output registers: synchronous reset, cleared (not held) while disabled.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            y     <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
        end else if (en) begin
            y     <= idx;
            valid <= any;
            multi <= cnt_gt1;
        end else begin
            // Forcing zeros here also keeps an unknown din out of the outputs.
            y     <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
        end
    end

endmodule

// File: tb/tb_encoder_8to3.sv
// Scoreboard bench for encoder_8to3: two instances (MSB and LSB priority)
// share the stimulus; each issued cycle pushes its expected result, and a
// monitor pops and compares one entry per cycle on the falling edge.
module tb_encoder_8to3;

    typedef struct packed {
        logic [2:0] y_m;
        logic [2:0] y_l;
        logic       v;
        logic       m;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] din;
    logic [2:0] y_msb, y_lsb;
    logic       valid_msb, valid_lsb, multi_msb, multi_lsb;

    int   n_pass;
    int   n_total;
    exp_t exp_q[$];

    encoder_8to3 #(.DIN_W(8), .Y_W(3), .MSB_PRIORITY(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en),
        .y(y_msb), .valid(valid_msb), .multi(multi_msb)
    );

    encoder_8to3 #(.DIN_W(8), .Y_W(3), .MSB_PRIORITY(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en),
        .y(y_lsb), .valid(valid_lsb), .multi(multi_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int ym, input int yl, input bit v, input bit m);
        exp_t e;
        e.y_m = 3'(ym);
        e.y_l = 3'(yl);
        e.v   = v;
        e.m   = m;
        return e;
    endfunction

    // Reference model: search from each end with early exit, count with $countones.
    function automatic exp_t model(input logic r, input logic e, input logic [7:0] d);
        exp_t res;
        res = '0;
        if (r && e) begin
            for (int i = 7; i >= 0; i--) begin
                if (d[i]) begin
                    res.y_m = 3'(i);
                    break;
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (d[i]) begin
                    res.y_l = 3'(i);
                    break;
                end
            end
            res.v = (d != 8'h00);
            res.m = ($countones(d) > 1);
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the result due after that edge.
    task automatic step(input logic r, input logic e, input logic [7:0] d, input exp_t ex);
        rst_n = r;
        en    = e;
        din   = d;
        @(posedge clk);
        #1;
        exp_q.push_back(ex);
    endtask

    // Monitor: one result per cycle, compared away from the rising edge.
    initial begin
        exp_t ex;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                check("y_msb",     {5'd0, y_msb},     {5'd0, ex.y_m});
                check("y_lsb",     {5'd0, y_lsb},     {5'd0, ex.y_l});
                check("valid_msb", {7'd0, valid_msb}, {7'd0, ex.v});
                check("valid_lsb", {7'd0, valid_lsb}, {7'd0, ex.v});
                check("multi_msb", {7'd0, multi_msb}, {7'd0, ex.m});
                check("multi_lsb", {7'd0, multi_lsb}, {7'd0, ex.m});
            end
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        din     = 8'h00;

        // Reset overrides en/din, then the first released edge encodes normally.
        step(1'b0, 1'b1, 8'hFF, mk(0, 0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 8'hFF, mk(0, 0, 1'b0, 1'b0));
        step(1'b1, 1'b1, 8'hFF, mk(7, 0, 1'b1, 1'b1));

        // Enable low clears outputs, including with unknown din.
        step(1'b1, 1'b0, 8'h01, mk(0, 0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 8'hxx, mk(0, 0, 1'b0, 1'b0));
        step(1'b1, 1'b1, 8'h01, mk(0, 0, 1'b1, 1'b0));

        // One-hot walk.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 8'(1 << k), mk(k, k, 1'b1, 1'b0));
        end

        // Multi-hot and all-zero.
        step(1'b1, 1'b1, 8'b0010_0100, mk(5, 2, 1'b1, 1'b1));
        step(1'b1, 1'b1, 8'h00,        mk(0, 0, 1'b0, 1'b0));
        step(1'b1, 1'b1, 8'b1000_0001, mk(7, 0, 1'b1, 1'b1));
        step(1'b1, 1'b1, 8'b0000_0011, mk(1, 0, 1'b1, 1'b1));

        // Walk with a one-cycle reset pulse in the middle.
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                step(1'b0, 1'b1, 8'(1 << k), mk(0, 0, 1'b0, 1'b0));
            end else begin
                step(1'b1, 1'b1, 8'(1 << k), mk(k, k, 1'b1, 1'b0));
            end
        end

        // Enable toggling every cycle.
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                step(1'b1, 1'b1, 8'h18, mk(4, 3, 1'b1, 1'b1));
            end else begin
                step(1'b1, 1'b0, 8'h18, mk(0, 0, 1'b0, 1'b0));
            end
        end

        // Exhaustive sweep against the reference model.
        for (int v = 0; v < 256; v++) begin
            step(1'b1, 1'b1, 8'(v), model(1'b1, 1'b1, 8'(v)));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/encoder_8to3.md
# encoder_8to3

Registered 8-to-3 binary encoder with enable. It converts an 8-bit request vector into the 3-bit index of the winning set bit, plus a valid flag and a multi-hot flag. It sits in the datapath wherever a one-hot (or arbitrary) request vector must be compressed to an index. Outputs are registered, with one clock of latency.

## Interface
Parameters:
- `DIN_W`, default 8 — input vector width; must be a power of two, at least 2.
- `Y_W`, default 3 — output index width; must equal log2(`DIN_W`).
- `MSB_PRIORITY`, default 1 — 1: the highest-index set bit wins; 0: the lowest-index set bit wins.

Ports:
- `clk`  in  1 — single clock; all state updates on the rising edge.
- `rst_n`  in  1 — synchronous, active-low reset.
- `din`  in  `DIN_W` — request vector.
- `en`  in  1 — encode enable, active high.
- `y`  out  `Y_W` — encoded index of the winning bit.
- `valid`  out  1 — the registered `y` corresponds to at least one set bit in `din`.
- `multi`  out  1 — more than one bit of `din` was set in the sampled cycle.

## Operation
- Combinational stage, every cycle:
  - `any` is the OR of all `din` bits.
  - `cnt_gt1` is set when two or more bits of `din` are 1.
  - `idx` is the index of the winning set bit, chosen per `MSB_PRIORITY`.
  - When `din` is all zeros, `idx` is 0.
- Register stage, on a rising `clk` edge:
  - `rst_n`=0: `y`=0, `valid`=0, `multi`=0. Reset overrides `en` and `din`.
  - `rst_n`=1 and `en`=0: `y`=0, `valid`=0, `multi`=0. The block is cleared, not held.
  - `rst_n`=1 and `en`=1: `y`=`idx`, `valid`=`any`, `multi`=`cnt_gt1`.
- One-hot input `din` = 1<<k gives `y`=k, `valid`=1, `multi`=0 for any k in 0..`DIN_W`-1.
- Multi-hot input:
  - `y` is the priority winner and `multi`=1.
  - Example: `din`=8'b0010_0100 gives `y`=5 when `MSB_PRIORITY`=1 and `y`=2 when `MSB_PRIORITY`=0.
- All-zero input with `en`=1: `y`=0, `valid`=0, `multi`=0.
  - Consumers must qualify `y` with `valid`; `y`=0 with `valid`=0 is not index 0.
- X or Z on `din` while `en`=0 must not propagate to the outputs.
- There is no internal state beyond the output registers, and there is no handshake.
  - A new `din` is accepted every cycle.

## Timing
- Latency is 1 cycle: the `din`/`en` values sampled at edge N appear on `y`, `valid` and `multi` immediately after edge N.
- Throughput is 1 result per cycle.
- Reset:
  - Asserting `rst_n` low for one edge clears all outputs after that edge.
  - Reset asserted mid-stream discards the in-flight result.
  - The first edge with `rst_n`=1 samples `din`/`en` normally.
- Enable:
  - Deasserting `en` clears the outputs at the next edge.
  - Reasserting `en` yields a valid result at the next edge.
- Outputs are glitch-free, driven directly from flops.
- `din` and `en` must meet setup/hold to `clk`. There is no internal synchronizer.

## Test plan
- Reset:
  - Drive `rst_n`=0 with `en`=1 and `din`=8'hFF for 2 cycles → `y`=0, `valid`=0, `multi`=0.
  - Release reset → the next edge gives `y`=7, `valid`=1, `multi`=1.
- Enable low:
  - With `en`=0, drive `din`=8'h01 → all outputs stay 0.
  - Set `en`=1 → the next edge gives `y`=0, `valid`=1, `multi`=0.
- One-hot walk with `en`=1:
  - Drive `din`=8'h01, 02, 04, 08, 10, 20, 40, 80 on consecutive cycles.
  - Expect `y`=0 through 7 with a 1-cycle lag, `valid`=1 and `multi`=0 throughout.
- Multi-hot and all-zero inputs:
  - `din`=8'b0010_0100 → `y`=5 (or `y`=2 with `MSB_PRIORITY`=0), `multi`=1.
  - `din`=8'h00 → `y`=0, `valid`=0, `multi`=0.
- Mid-stream events:
  - Assert `rst_n`=0 for one cycle during the walk → outputs are 0 for that cycle, and the walk resumes the cycle after.
  - Toggle `en` every cycle → `valid` alternates with a 1-cycle lag.
- Exhaustive sweep: run all 256 `din` values with `en`=1 and compare against a reference model.
  - Check `y`, `valid` and `multi` for both `MSB_PRIORITY` settings.
